// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control logic.
//   - opcode constants used by hazard decode
//   - NOP encoding (all zeros)
//   - hazard controller state enum
//   - uses_rt(): whether an opcode reads the rt field as a source
package pipe_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_SW    = 6'h2B;

  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REPLAY = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // rt is a source operand only for R-type ALU ops, the two compare
  // branches and stores; for loads and immediates it is the destination.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
           (opcode == OP_BNE)   || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller.
//   master: the pipeline datapath (drives ID/EX status, consumes controls)
//   slave : hazard_ctrl (consumes status, drives IF/ID, ID/EX and PC controls)
// Signals:
//   id_inst, id_pc4                 - instruction in ID and its PC+4
//   ex_memread, ex_rt               - load in EX and its destination register
//   ex_branch_taken, ex_branch_target - branch resolved taken in EX, target
//   hazard_hold, idex_flush         - IF/ID and ID/EX kill controls
//   pc_write, pc_redirect, pc_redirect_addr - PC update controls
interface hazard_ctrl_if;

  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;

  logic        hazard_hold;
  logic        idex_flush;
  logic        pc_write;
  logic        pc_redirect;
  logic [31:0] pc_redirect_addr;

  modport master (
    output id_inst, id_pc4, ex_memread, ex_rt, ex_branch_taken, ex_branch_target,
    input  hazard_hold, idex_flush, pc_write, pc_redirect, pc_redirect_addr
  );

  modport slave (
    input  id_inst, id_pc4, ex_memread, ex_rt, ex_branch_taken, ex_branch_target,
    output hazard_hold, idex_flush, pc_write, pc_redirect, pc_redirect_addr
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
//   clk   - rising-edge clock
//   clr_n - synchronous active-low clear
//   inc   - count one event this cycle
//   count - current value; holds at all-ones once reached
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline.
// Detects load-use hazards on the instruction in ID and resolves them by
// killing ID/EX, turning IF/ID into a nop and refetching the ID instruction
// (PC+4 - 4). Taken branches resolved in EX squash IF and ID and redirect
// fetch to the branch target; a branch always wins over a load-use hazard.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-low reset
//   bus            - pipeline status in / pipeline controls out (slave side)
//   stall_count    - saturating count of load-use replays
//   flush_count    - saturating count of taken-branch flushes
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  hazard_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_e      state_d;
  state_e      state_q;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        load_use;

  logic        hold;
  logic        flush;
  logic        pc_we;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        stall_inc;
  logic        flush_inc;

  assign opcode = bus.id_inst[31:26];
  assign rs     = bus.id_inst[25:21];
  assign rt     = bus.id_inst[20:16];

  // $0 is never a real dependency, and a nop in ID (e.g. the bubble left by
  // a previous replay) never stalls even though its fields decode as zero.
  assign load_use = bus.ex_memread
                  && (bus.ex_rt != 5'd0)
                  && ((bus.ex_rt == rs) || (uses_rt(opcode) && (bus.ex_rt == rt)))
                  && (bus.id_inst != NOP);

  always_comb begin
    hold          = 1'b0;
    flush         = 1'b0;
    pc_we         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 32'h0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    state_d       = RUN;

    // In reset every control stays low, including pc_write, so the PC
    // does not advance while the pipeline is being cleared.
    if (reset) begin
      pc_we = 1'b1;
      if (bus.ex_branch_taken) begin
        hold          = 1'b1;
        flush         = 1'b1;
        redirect      = 1'b1;
        redirect_addr = bus.ex_branch_target;
        flush_inc     = 1'b1;
        state_d       = FLUSH;
      end else if ((state_q == RUN) && load_use) begin
        // Refetch the ID instruction; by the time it is back in ID the
        // load has reached MEM and normal forwarding covers it.
        hold          = 1'b1;
        flush         = 1'b1;
        redirect      = 1'b1;
        redirect_addr = bus.id_pc4 - 32'd4;
        stall_inc     = 1'b1;
        state_d       = REPLAY;
      end
      // REPLAY and FLUSH last one cycle with default outputs, which also
      // masks the stale load-use seen against the inserted nop.
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.hazard_hold      = hold;
  assign bus.idex_flush       = flush;
  assign bus.pc_write         = pc_we;
  assign bus.pc_redirect      = redirect;
  assign bus.pc_redirect_addr = redirect_addr;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clock),
    .clr_n (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clock),
    .clr_n (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a 16-bit-counter instance and a 2-bit-counter
// instance share the same stimulus; an event-level model predicts outputs.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;

  hazard_ctrl_if bus16 ();
  hazard_ctrl_if bus2 ();

  logic [15:0] stall16, flush16;
  logic [1:0]  stall2, flush2;

  hazard_ctrl #(.CNT_W(16)) dut16 (
    .clock       (clk),
    .reset       (rst_n),
    .bus         (bus16),
    .stall_count (stall16),
    .flush_count (flush16)
  );

  hazard_ctrl #(.CNT_W(2)) dut2 (
    .clock       (clk),
    .reset       (rst_n),
    .bus         (bus2),
    .stall_count (stall2),
    .flush_count (flush2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // busy: the previous cycle issued a replay or flush, so a load-use seen
  // now is against the bubble and must not fire again.
  bit armed = 0;
  bit busy  = 0;
  int n_stall = 0;
  int n_flush = 0;

  function automatic bit model_load_use();
    logic [5:0] op;
    logic [4:0] rs, rt;
    bit rt_src;
    op = bus16.id_inst[31:26];
    rs = bus16.id_inst[25:21];
    rt = bus16.id_inst[20:16];
    rt_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    if (!bus16.ex_memread || bus16.ex_rt == 0 || bus16.id_inst == 0) return 0;
    return (bus16.ex_rt == rs) || (rt_src && bus16.ex_rt == rt);
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      armed   = 1;
      busy    = 0;
      n_stall = 0;
      n_flush = 0;
    end else if (bus16.ex_branch_taken) begin
      n_flush++;
      busy = 1;
    end else if (model_load_use() && !busy) begin
      n_stall++;
      busy = 1;
    end else begin
      busy = 0;
    end
  end

  // One compare pass per cycle, away from the active edge.
  always @(negedge clk) begin
    logic        e_hold, e_flush, e_pcw, e_redir;
    logic [31:0] e_addr;
    if (armed) begin
      e_hold = 0; e_flush = 0; e_pcw = 0; e_redir = 0; e_addr = 0;
      if (rst_n) begin
        e_pcw = 1;
        if (bus16.ex_branch_taken) begin
          e_hold = 1; e_flush = 1; e_redir = 1; e_addr = bus16.ex_branch_target;
        end else if (model_load_use() && !busy) begin
          e_hold = 1; e_flush = 1; e_redir = 1; e_addr = bus16.id_pc4 - 32'd4;
        end
      end
      chk("hold16",  {31'b0, bus16.hazard_hold}, {31'b0, e_hold});
      chk("flush16", {31'b0, bus16.idex_flush},  {31'b0, e_flush});
      chk("pcw16",   {31'b0, bus16.pc_write},    {31'b0, e_pcw});
      chk("redir16", {31'b0, bus16.pc_redirect}, {31'b0, e_redir});
      chk("addr16",  bus16.pc_redirect_addr,     e_addr);
      chk("scnt16",  {16'b0, stall16},           sat(n_stall, 16));
      chk("fcnt16",  {16'b0, flush16},           sat(n_flush, 16));
      chk("hold2",   {31'b0, bus2.hazard_hold},  {31'b0, e_hold});
      chk("redir2",  {31'b0, bus2.pc_redirect},  {31'b0, e_redir});
      chk("addr2",   bus2.pc_redirect_addr,      e_addr);
      chk("scnt2",   {30'b0, stall2},            sat(n_stall, 2));
      chk("fcnt2",   {30'b0, flush2},            sat(n_flush, 2));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [31:0] inst, input logic [31:0] pc4,
                       input logic mr, input logic [4:0] ert,
                       input logic bt, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst_n = r;
    bus16.id_inst = inst; bus16.id_pc4 = pc4; bus16.ex_memread = mr;
    bus16.ex_rt = ert; bus16.ex_branch_taken = bt; bus16.ex_branch_target = tgt;
    bus2.id_inst = inst;  bus2.id_pc4 = pc4;  bus2.ex_memread = mr;
    bus2.ex_rt = ert;  bus2.ex_branch_taken = bt;  bus2.ex_branch_target = tgt;
    @(negedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD_889 = 32'h0109_4020;  // add $8,$8,$9
  localparam logic [31:0] LW_849  = 32'h8D28_0004;  // lw  $8,4($9)
  localparam logic [31:0] SW_849  = 32'hAD28_0004;  // sw  $8,4($9)
  localparam logic [31:0] ADD_800 = 32'h0000_4020;  // add $8,$0,$0

  initial begin
    rst_n = 0;
    bus16.id_inst = 0; bus16.id_pc4 = 0; bus16.ex_memread = 0;
    bus16.ex_rt = 0; bus16.ex_branch_taken = 0; bus16.ex_branch_target = 0;
    bus2.id_inst = 0; bus2.id_pc4 = 0; bus2.ex_memread = 0;
    bus2.ex_rt = 0; bus2.ex_branch_taken = 0; bus2.ex_branch_target = 0;

    // Reset with random inputs: everything quiet.
    for (int i = 0; i < 3; i++) begin
      drive(0, $urandom, $urandom, 1'b1, 5'd8, 1'b1, $urandom);
      chk("rst_pcw", {31'b0, bus16.pc_write}, 32'd0);
      chk("rst_hold", {31'b0, bus16.hazard_hold}, 32'd0);
      chk("rst_scnt", {16'b0, stall16}, 32'd0);
    end

    drive(1, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("post_rst_pcw", {31'b0, bus16.pc_write}, 32'd1);

    // Load-use on rs.
    drive(1, ADD_889, 32'h100, 1, 5'd8, 0, 0);
    chk("lu_rs_hold",  {31'b0, bus16.hazard_hold}, 32'd1);
    chk("lu_rs_flush", {31'b0, bus16.idex_flush},  32'd1);
    chk("lu_rs_addr",  bus16.pc_redirect_addr,     32'h0000_00FC);
    // Same inputs in REPLAY: masked.
    drive(1, ADD_889, 32'h100, 1, 5'd8, 0, 0);
    chk("replay_redir", {31'b0, bus16.pc_redirect}, 32'd0);
    chk("replay_scnt",  {16'b0, stall16},           32'd1);
    drive(1, 32'h0, 32'h0, 0, 0, 0, 0);

    // rt filtering.
    drive(1, LW_849, 32'h200, 1, 5'd8, 0, 0);
    chk("lw_rt_nohaz", {31'b0, bus16.hazard_hold}, 32'd0);
    drive(1, SW_849, 32'h204, 1, 5'd8, 0, 0);
    chk("sw_rt_haz",  {31'b0, bus16.hazard_hold}, 32'd1);
    chk("sw_rt_addr", bus16.pc_redirect_addr,     32'h0000_0200);
    drive(1, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("sw_scnt", {16'b0, stall16}, 32'd2);
    drive(1, ADD_800, 32'h300, 1, 5'd0, 0, 0);
    chk("rt0_nohaz", {31'b0, bus16.hazard_hold}, 32'd0);

    // Branch wins over simultaneous load-use.
    drive(1, ADD_889, 32'h100, 1, 5'd8, 1, 32'h400);
    chk("br_addr",  bus16.pc_redirect_addr,     32'h0000_0400);
    chk("br_redir", {31'b0, bus16.pc_redirect}, 32'd1);
    drive(1, ADD_889, 32'h100, 1, 5'd8, 0, 0);
    chk("br_fcnt",     {16'b0, flush16},           32'd1);
    chk("br_scnt",     {16'b0, stall16},           32'd2);
    chk("flush_state", {31'b0, bus16.hazard_hold}, 32'd0);

    // PC+4 of zero wraps.
    drive(1, ADD_889, 32'h0, 1, 5'd8, 0, 0);
    chk("wrap_addr", bus16.pc_redirect_addr, 32'hFFFF_FFFC);
    drive(1, 32'h0, 32'h0, 0, 0, 0, 0);

    // Five back-to-back branches: 2-bit counter stops at 3.
    for (int i = 0; i < 5; i++) drive(1, 32'h0, 32'h0, 0, 0, 1, 32'h800 + i * 4);
    drive(1, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("sat_fcnt2",  {30'b0, flush2},  32'd3);
    chk("sat_fcnt16", {16'b0, flush16}, 32'd6);

    // Reset in the middle of a replay.
    drive(1, ADD_889, 32'h100, 1, 5'd8, 0, 0);
    drive(0, ADD_889, 32'h100, 1, 5'd8, 0, 0);
    chk("rst_mid_hold", {31'b0, bus16.hazard_hold}, 32'd0);
    drive(1, ADD_889, 32'h100, 1, 5'd8, 0, 0);
    chk("rel_haz",  {31'b0, bus16.hazard_hold}, 32'd1);
    chk("rel_scnt", {16'b0, stall16},           32'd0);
    drive(1, ADD_889, 32'h100, 1, 5'd8, 0, 0);
    chk("rel_scnt1", {16'b0, stall16}, 32'd1);

    // Mixed traffic checked against the model only.
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [31:0] inst;
      case ($urandom_range(0, 4))
        0: op = 6'h00; 1: op = 6'h04; 2: op = 6'h23; 3: op = 6'h2B; default: op = 6'h08;
      endcase
      inst = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      if ($urandom_range(0, 7) == 0) inst = 32'h0;
      drive(($urandom_range(0, 15) != 0), inst, $urandom, 1'($urandom),
            5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), $urandom);
    end

    drive(1, 32'h0, 32'h0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
